fg_phase_gen: RTL and testbench
===============================

Name: fg_phase_gen

Overview:
Phase-generation stage directly upstream of the function generator's CORDIC rotator. It holds a frequency tuning word (FTW) and a phase offset, runs a phase accumulator, and emits a signed phase word each enabled cycle. 2^BITWIDTH_PHASE LSBs = 360°, 2^(BITWIDTH_PHASE-3) = 45°, top two bits = quadrant. It also produces a valid flag delayed to line up with the CORDIC output and accepts glitch-free configuration updates through a valid/ready handshake.

Parameters:
BITWIDTH_PHASE, 10, width of phase_o and phase_offset_i (must match the CORDIC phase width)
BITWIDTH_ACC, 24, accumulator and FTW width (≥ BITWIDTH_PHASE)
CORDIC_LATENCY, 8, enabled-cycle latency of the downstream CORDIC (its BITWIDTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clk_en_i  in  1  clock enable shared with the CORDIC; all non-reset state advances only when high
enable_i  in  1  run request; low = stop and clear phase
sync_i  in  1  phase restart pulse (sampled on enabled cycles)
cfg_valid_i  in  1  new configuration offered
cfg_ready_o  out  1  configuration accepted when high together with cfg_valid_i
freq_word_i  in  BITWIDTH_ACC  FTW, unsigned
phase_offset_i  in  BITWIDTH_PHASE  phase offset, wraps modulo 360°
phase_o  out  BITWIDTH_PHASE  signed phase to the CORDIC phase_i
phase_valid_o  out  1  phase_o is valid
out_valid_o  out  1  phase_valid_o delayed by CORDIC_LATENCY enabled cycles (marks valid CORDIC sine/cosine)
wrap_o  out  1  one-cycle pulse: accumulator carried out on the last enabled cycle

Behaviour:
- Reset (rst_i high at the edge; takes priority over everything): accumulator = 0, active FTW/offset = 0, shadow regs = 0, state = IDLE. phase_o, phase_valid_o, out_valid_o and wrap_o are all 0. The delay line is cleared.
- cfg_ready_o = clk_en_i && !rst_i && state != PEND (combinational).
- A transfer happens when cfg_valid_i && cfg_ready_o. freq_word_i and phase_offset_i are latched into the shadow regs.
- State machine (evaluated on enabled cycles only):
  IDLE: acc held at 0. A transfer copies the shadow straight to the active regs. enable_i = 1 → RUN (a transfer in that same cycle is still applied).
  RUN: acc <= acc + FTW_active, modulo 2^BITWIDTH_ACC. A transfer → PEND.
  PEND: same as RUN. On a carry-out (wrap) or on sync_i, active <= shadow and the state returns to RUN. The new FTW drives the next increment.
  In RUN or PEND, enable_i = 0 → IDLE, acc <= 0. Any pending shadow is applied to the active regs.
- sync_i in RUN/PEND: acc <= 0 instead of incrementing, and no wrap_o. sync_i in IDLE is ignored.
- Simultaneous events:
  - sync_i and carry in the same cycle: sync wins.
  - enable_i = 0 beats sync_i.
  - A transfer in the same cycle as a wrap while in RUN goes to PEND and waits for the next wrap; it is not applied immediately.
- Output register, updated on enabled cycles:
  - phase_o <= acc[BITWIDTH_ACC-1 -: BITWIDTH_PHASE] + offset_active, truncating add, natural wrap.
  - phase_valid_o <= (state != IDLE).
  - wrap_o <= carry of this cycle's increment.
- Output latency: enable_i first sampled high at enabled cycle k gives RUN at k+1. phase_o = offset with phase_valid_o = 1 at k+2, then offset + step at k+3, and so on.
- out_valid_o: shift register of depth CORDIC_LATENCY fed by phase_valid_o. It shifts only when clk_en_i is high.
- clk_en_i low: all registers hold, except that wrap_o is forced to 0.
- Reset mid-operation: immediate return to the reset values on the next edge; the pending config is lost.

Decomposition:
- Shared package fg_pkg:
  - localparams FG_PHASE_W = 10, FG_ACC_W = 24, FG_CORDIC_LAT = 8.
  - state encoding constants FG_PG_IDLE = 2'd0, FG_PG_RUN = 2'd1, FG_PG_PEND = 2'd2.
- One sub-module: fg_valid_delay (parameter DEPTH; clk_i, rst_i, clk_en_i, d_i, q_o), an enabled shift register. It is reused later for other CORDIC-aligned side-band flags.

Test Plan:
- Basic ramp: reset, cfg FTW = 0x040000, offset = 0, enable_i = 1, clk_en_i = 1. Required: phase_o = 0, 16, 32, …, 1008, 0. wrap_o pulses every 64 cycles. out_valid_o rises 8 cycles after phase_valid_o.
- Offset wrap: offset = 256 (90°), FTW = 0x040000. Required: phase_o starts 256, 272, … and wraps from 1008 to 0 at the 48th sample.
- Glitch-free retune: while running at FTW = 0x040000, offer FTW = 0x080000 at phase 160. Required: cfg_ready_o drops until the wrap. The step stays 16 until acc wraps to 0, then becomes 32. No transfer is accepted while in PEND.
- Sync and events: assert sync_i at phase 400. Required: the next phase_o = offset with no wrap_o. Assert sync_i together with a pending config: the new FTW is applied and the state is RUN.
- Clock-enable gating: toggle clk_en_i 1/0/1/0. Required: phase_o advances only on enabled cycles. out_valid_o delay counts 8 enabled cycles. wrap_o is never high while clk_en_i = 0.
- Reset and stop: assert rst_i while in PEND. Required: all outputs 0 and cfg_ready_o = 1 on the next enabled cycle. enable_i = 0 while running: phase_valid_o = 0 next enabled cycle, acc cleared, out_valid_o falls 8 enabled cycles later.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared constants for the function-generator datapath: default widths,
// CORDIC alignment latency and the phase-generator state encoding.
package fg_pkg;

  localparam int FG_PHASE_W    = 10;
  localparam int FG_ACC_W      = 24;
  localparam int FG_CORDIC_LAT = 8;

  localparam logic [1:0] FG_PG_IDLE = 2'd0;
  localparam logic [1:0] FG_PG_RUN  = 2'd1;
  localparam logic [1:0] FG_PG_PEND = 2'd2;

endpackage

// File: rtl/fg_phase_gen_if.sv
// Configuration handshake between a controller (master) and the phase
// generator (slave): tuning word and phase offset offered under valid/ready.
interface fg_phase_gen_if
  import fg_pkg::*;
#(
  parameter int PW = FG_PHASE_W,
  parameter int AW = FG_ACC_W
);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] freq_word;
  logic [PW-1:0] phase_offset;

  modport master (output cfg_valid, freq_word, phase_offset, input cfg_ready);
  modport slave  (input cfg_valid, freq_word, phase_offset, output cfg_ready);

endinterface

// File: rtl/fg_valid_delay.sv
// Clock-enabled shift register that aligns a side-band flag with the CORDIC
// output; it advances only on cycles where clk_en_i is high.
module fg_valid_delay #(
  parameter int DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_en_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sr_d = sr_q;
    if (clk_en_i) begin
      sr_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  // NOTE: the delay line is a handful of flops, so it is reset like any other state.
  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fg_phase_gen.sv
// Phase accumulator feeding the CORDIC rotator, with glitch-free retuning:
// a new FTW/offset waits in a shadow register until the accumulator wraps or a sync.
module fg_phase_gen
  import fg_pkg::*;
#(
  parameter int BITWIDTH_PHASE = FG_PHASE_W,
  parameter int BITWIDTH_ACC   = FG_ACC_W,
  parameter int CORDIC_LATENCY = FG_CORDIC_LAT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  input  logic                      enable_i,
  input  logic                      sync_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [BITWIDTH_ACC-1:0]   freq_word_i,
  input  logic [BITWIDTH_PHASE-1:0] phase_offset_i,
  output logic [BITWIDTH_PHASE-1:0] phase_o,
  output logic                      phase_valid_o,
  output logic                      out_valid_o,
  output logic                      wrap_o
);

  localparam int PW = BITWIDTH_PHASE;
  localparam int AW = BITWIDTH_ACC;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, ftw_q, ftw_d, ftw_sh_q, ftw_sh_d;
  logic [PW-1:0] off_q, off_d, off_sh_q, off_sh_d, phase_q, phase_d;
  logic          phase_valid_q, phase_valid_d, wrap_q, wrap_d;
  logic [AW:0]   sum;
  logic [AW-1:0] ftw_next;
  logic [PW-1:0] off_next;
  logic          xfer, carry, running;

  assign cfg_ready_o = clk_en_i && !rst_i && (state_q != FG_PG_PEND);
  assign xfer        = cfg_valid_i && cfg_ready_o;
  assign sum         = {1'b0, acc_q} + {1'b0, ftw_q};
  assign carry       = sum[AW];
  assign running     = (state_q == FG_PG_RUN) || (state_q == FG_PG_PEND);

  // Outside PEND the shadow equals the active config, so this is "latest accepted".
  assign ftw_next = xfer ? freq_word_i    : ftw_sh_q;
  assign off_next = xfer ? phase_offset_i : off_sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FG_PG_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clk_en_i) begin
      case (state_q)
        FG_PG_IDLE: if (enable_i) state_d = FG_PG_RUN;
        FG_PG_RUN: begin
          if (!enable_i)  state_d = FG_PG_IDLE;
          else if (xfer)  state_d = FG_PG_PEND;
        end
        FG_PG_PEND: begin
          if (!enable_i)             state_d = FG_PG_IDLE;
          else if (sync_i || carry)  state_d = FG_PG_RUN;
        end
        default: state_d = FG_PG_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d         = acc_q;
    ftw_d         = ftw_q;
    off_d         = off_q;
    ftw_sh_d      = ftw_next;
    off_sh_d      = off_next;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    wrap_d        = 1'b0;
    if (clk_en_i) begin
      phase_d       = acc_q[AW-1 -: PW] + off_q;
      phase_valid_d = running;
      if (!running || !enable_i) begin
        acc_d = '0;
        ftw_d = ftw_next;
        off_d = off_next;
      end else if (sync_i) begin
        acc_d = '0;
        if (state_q == FG_PG_PEND) begin
          ftw_d = ftw_sh_q;
          off_d = off_sh_q;
        end
      end else begin
        acc_d  = sum[AW-1:0];
        wrap_d = carry;
        if (state_q == FG_PG_PEND && carry) begin
          ftw_d = ftw_sh_q;
          off_d = off_sh_q;
        end
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q         <= '0;
      ftw_q         <= '0;
      off_q         <= '0;
      ftw_sh_q      <= '0;
      off_sh_q      <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      ftw_q         <= ftw_d;
      off_q         <= off_d;
      ftw_sh_q      <= ftw_sh_d;
      off_sh_q      <= off_sh_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  fg_valid_delay #(
    .DEPTH (CORDIC_LATENCY)
  ) u_valid_delay (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_en_i (clk_en_i),
    .d_i      (phase_valid_q),
    .q_o      (out_valid_o)
  );

  assign phase_o       = phase_q;
  assign phase_valid_o = phase_valid_q;
  assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_fg_phase_gen.sv
// Directed bench for fg_phase_gen: ramp, offset wrap, retune, sync, clock-enable
// gating, stop and reset, all against hand-computed phase sequences.
`timescale 1ns/1ps
module tb_fg_phase_gen;

  logic       clk = 1'b0;
  logic       rst, clk_en, enable, sync;
  logic [9:0] phase;
  logic       pval, oval, wrap;
  int         n_checks = 0;
  int         n_errors = 0;

  fg_phase_gen_if #(.PW(10), .AW(24)) cfg_if ();

  fg_phase_gen dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_en_i       (clk_en),
    .enable_i       (enable),
    .sync_i         (sync),
    .cfg_valid_i    (cfg_if.cfg_valid),
    .cfg_ready_o    (cfg_if.cfg_ready),
    .freq_word_i    (cfg_if.freq_word),
    .phase_offset_i (cfg_if.phase_offset),
    .phase_o        (phase),
    .phase_valid_o  (pval),
    .out_valid_o    (oval),
    .wrap_o         (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'b1; enable = 1'b0; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.freq_word = '0; cfg_if.phase_offset = '0;
    ticks(2);
    rst = 1'b0;
  endtask

  // Transfer and enable in the same IDLE cycle; returns at the first valid sample.
  task automatic start(input logic [23:0] ftw, input logic [9:0] off);
    cfg_if.cfg_valid = 1'b1; cfg_if.freq_word = ftw; cfg_if.phase_offset = off;
    enable = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ready_in_reset", cfg_if.cfg_ready, 0);
    check("rst_phase", phase, 0);
    check("rst_pval", pval, 0);
    check("rst_oval", oval, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", cfg_if.cfg_ready, 1);

    // Basic ramp: step 16, wrap every 64 samples, out_valid 8 cycles late
    start(24'h040000, 10'd0);
    for (int i = 0; i < 70; i++) begin
      if (i > 0) tick();
      check("ramp_phase", phase, (16 * i) % 1024);
      check("ramp_wrap", wrap, (i % 64) == 63);
      check("ramp_oval", oval, i >= 8);
      check("ramp_pval", pval, 1);
    end

    // Stop: valid drops, out_valid follows 8 enabled cycles later, acc cleared
    enable = 1'b0;
    ticks(2);
    check("stop_pval", pval, 0);
    ticks(7);
    check("stop_oval_held", oval, 1);
    tick();
    check("stop_oval_fall", oval, 0);
    enable = 1'b1;
    ticks(2);
    check("restart_pval", pval, 1);
    check("restart_phase", phase, 0);

    // Offset wrap: 256 + 16*j, 1008 then 0 at j = 47/48
    do_reset();
    start(24'h040000, 10'd256);
    for (int j = 0; j < 50; j++) begin
      if (j > 0) tick();
      check("offs_phase", phase, (256 + 16 * j) % 1024);
      check("offs_wrap", wrap, 0);
    end

    // Glitch-free retune from step 16 to step 32
    do_reset();
    start(24'h040000, 10'd0);
    ticks(10);
    check("retune_at160", phase, 160);
    cfg_if.cfg_valid = 1'b1; cfg_if.freq_word = 24'h080000;
    #1;
    check("retune_ready_run", cfg_if.cfg_ready, 1);
    tick();
    cfg_if.freq_word = 24'h0C0000;  // must not be accepted while pending
    for (int s = 11; s < 63; s++) begin
      if (s > 11) tick();
      check("retune_pend_phase", phase, 16 * s);
      check("retune_pend_ready", cfg_if.cfg_ready, 0);
    end
    tick();
    check("retune_wrap_phase", phase, 1008);
    check("retune_wrap", wrap, 1);
    cfg_if.cfg_valid = 1'b0;
    #1;
    check("retune_ready_back", cfg_if.cfg_ready, 1);
    for (int m = 0; m < 3; m++) begin
      tick();
      check("retune_new_step", phase, 32 * m);
    end

    // Transfer in the same cycle as a wrap in RUN waits in PEND
    ticks(28);
    check("wrapx_pre", phase, 960);
    cfg_if.cfg_valid = 1'b1; cfg_if.freq_word = 24'h040000;
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("wrapx_phase", phase, 992);
    check("wrapx_wrap", wrap, 1);
    tick();
    check("wrapx_phase0", phase, 0);
    check("wrapx_ready_pend", cfg_if.cfg_ready, 0);
    tick();
    check("wrapx_old_step", phase, 32);

    // Sync with pending config: applied immediately, back to RUN
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("syncp_phase", phase, 64);
    check("syncp_wrap", wrap, 0);
    check("syncp_ready_run", cfg_if.cfg_ready, 1);
    tick();
    check("syncp_restart", phase, 0);
    tick();
    check("syncp_new_step", phase, 16);

    // Sync at phase 400 restarts at the offset; sync beats a carry
    do_reset();
    start(24'h040000, 10'd256);
    ticks(9);
    check("sync_at400", phase, 400);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_phase", phase, 416);
    check("sync_nowrap", wrap, 0);
    tick();
    check("sync_offset", phase, 256);
    ticks(62);
    check("syncc_pre", phase, 224);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("syncc_phase", phase, 240);
    check("syncc_nowrap", wrap, 0);
    tick();
    check("syncc_offset", phase, 256);
    check("syncc_nowrap2", wrap, 0);

    // Clock-enable gating
    do_reset();
    start(24'h040000, 10'd0);
    check("gate_oval0", oval, 0);
    for (int p = 1; p <= 10; p++) begin
      clk_en = 1'b0;
      #1;
      check("gate_ready_off", cfg_if.cfg_ready, 0);
      tick();
      check("gate_hold_phase", phase, 16 * (p - 1));
      check("gate_hold_oval", oval, (p - 1) >= 8);
      check("gate_hold_wrap", wrap, 0);
      clk_en = 1'b1;
      tick();
      check("gate_adv_phase", phase, 16 * p);
      check("gate_adv_oval", oval, p >= 8);
    end
    ticks(52);
    check("gate_pre_wrap", phase, 992);
    tick();
    check("gate_wrap_phase", phase, 1008);
    check("gate_wrap", wrap, 1);
    clk_en = 1'b0;
    tick();
    check("gate_wrap_held_phase", phase, 1008);
    check("gate_wrap_forced0", wrap, 0);
    check("gate_pval_held", pval, 1);
    clk_en = 1'b1;
    tick();
    check("gate_after_phase", phase, 0);
    check("gate_after_wrap", wrap, 0);

    // Reset while in PEND: pending config lost
    do_reset();
    start(24'h040000, 10'd0);
    tick();
    cfg_if.cfg_valid = 1'b1; cfg_if.freq_word = 24'h080000;
    tick();
    cfg_if.cfg_valid = 1'b0;
    #1;
    check("rstp_ready_pend", cfg_if.cfg_ready, 0);
    rst = 1'b1;
    tick();
    check("rstp_phase", phase, 0);
    check("rstp_pval", pval, 0);
    check("rstp_oval", oval, 0);
    check("rstp_wrap", wrap, 0);
    rst = 1'b0;
    #1;
    check("rstp_ready", cfg_if.cfg_ready, 1);
    enable = 1'b1;
    ticks(2);
    check("rstp_run_pval", pval, 1);
    check("rstp_run_phase0", phase, 0);
    tick();
    check("rstp_ftw_cleared", phase, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
